// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, sequencer
// state encoding, accumulate modes and default latencies.
package mdu_ctrl_pkg;

  // MDU operation codes carried on mdu_op
  localparam logic [3:0] MDU_none  = 4'd0;
  localparam logic [3:0] MDU_mult  = 4'd1;
  localparam logic [3:0] MDU_multu = 4'd2;
  localparam logic [3:0] MDU_div   = 4'd3;
  localparam logic [3:0] MDU_divu  = 4'd4;
  localparam logic [3:0] MDU_mthi  = 4'd5;
  localparam logic [3:0] MDU_mtlo  = 4'd6;
  localparam logic [3:0] MDU_mfhi  = 4'd7;
  localparam logic [3:0] MDU_mflo  = 4'd8;
  localparam logic [3:0] MDU_madd  = 4'd9;
  localparam logic [3:0] MDU_maddu = 4'd10;
  localparam logic [3:0] MDU_msub  = 4'd11;

  // Default latencies (cycles busy is held)
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

  // How the staged product is folded into {HI,LO} at completion
  typedef enum logic [1:0] {
    ACC_SET = 2'd0,
    ACC_ADD = 2'd1,
    ACC_SUB = 2'd2
  } mdu_acc_t;

  // Ops that interpret their operands as two's complement
  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == MDU_mult) || (op == MDU_div) ||
           (op == MDU_madd) || (op == MDU_msub);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Purely combinational MDU datapath: 64-bit product, quotient/remainder,
// divide-by-zero flag and the signed INT_MIN / -1 overflow case.
// Division works on magnitudes so the signed result truncates toward zero
// and the remainder follows the dividend's sign.
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sgn,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero,
  output logic        div_ovf
);

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] safe_b;
  logic [31:0] uq;
  logic [31:0] ur;

  // Product, magnitude division and sign fix-up
  always_comb begin
    ext_a    = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b    = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod     = ext_a * ext_b;
    neg_a    = sgn & a[31];
    neg_b    = sgn & b[31];
    mag_a    = neg_a ? (32'd0 - a) : a;
    mag_b    = neg_b ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    div_ovf  = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    // A zero divisor is replaced so the divider never sees /0; the
    // controller discards the result in that case anyway.
    safe_b   = div_zero ? 32'd1 : mag_b;
    uq       = mag_a / safe_b;
    ur       = mag_a % safe_b;
    quot     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem      = neg_a ? (32'd0 - ur) : ur;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO.
// Optional feature macro: MDU_MADD_EN adds madd/maddu/msub accumulate ops.
// Handshake: start is a single-cycle request qualified by mdu_op; it is
// only accepted in IDLE (busy==0). Results appear in HI/LO in the first
// cycle busy is low; requests seen while busy are dropped.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  mdu_state_t       state;
  logic [CNT_W-1:0] counter;
  logic [63:0]      stage;
  logic             stage_keep;
  logic             is_mul;
  logic             is_div;
  logic [63:0]      prod;
  logic [31:0]      quot;
  logic [31:0]      rem;
  logic             div_zero;
  logic             div_ovf;
`ifdef MDU_MADD_EN
  mdu_acc_t         acc;
  mdu_acc_t         acc_sel;
`endif

  mdu_arith u_arith (
    .a        (A),
    .b        (B),
    .sgn      (op_is_signed(mdu_op)),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero),
    .div_ovf  (div_ovf)
  );

  // Op class decode; accumulate ops only exist when the feature is built
  always_comb begin
    is_div = (mdu_op == MDU_div) || (mdu_op == MDU_divu);
`ifdef MDU_MADD_EN
    is_mul  = (mdu_op == MDU_mult) || (mdu_op == MDU_multu) ||
              (mdu_op == MDU_madd) || (mdu_op == MDU_maddu) ||
              (mdu_op == MDU_msub);
    acc_sel = ACC_SET;
    if ((mdu_op == MDU_madd) || (mdu_op == MDU_maddu)) acc_sel = ACC_ADD;
    else if (mdu_op == MDU_msub)                        acc_sel = ACC_SUB;
`else
    is_mul = (mdu_op == MDU_mult) || (mdu_op == MDU_multu);
`endif
  end

  // Sequencer: accepts ops in IDLE, counts latency, commits staging to HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      HI         <= 32'd0;
      LO         <= 32'd0;
      counter    <= '0;
      stage      <= 64'd0;
      stage_keep <= 1'b0;
`ifdef MDU_MADD_EN
      acc        <= ACC_SET;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul) begin
              stage      <= prod;
              stage_keep <= 1'b0;
`ifdef MDU_MADD_EN
              acc        <= acc_sel;
`endif
              counter    <= CNT_W'(MULT_CYCLES - 1);
              busy       <= 1'b1;
              state      <= ST_MUL;
            end else if (is_div) begin
              stage      <= div_ovf ? {32'd0, 32'h8000_0000} : {rem, quot};
              stage_keep <= div_zero;
`ifdef MDU_MADD_EN
              acc        <= ACC_SET;
`endif
              counter    <= CNT_W'(DIV_CYCLES - 1);
              busy       <= 1'b1;
              state      <= ST_DIV;
            end else if (mdu_op == MDU_mthi) begin
              HI <= A;
            end else if (mdu_op == MDU_mtlo) begin
              LO <= A;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (counter == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!stage_keep) begin
`ifdef MDU_MADD_EN
              case (acc)
                ACC_ADD: {HI, LO} <= {HI, LO} + stage;
                ACC_SUB: {HI, LO} <= {HI, LO} - stage;
                default: {HI, LO} <= stage;
              endcase
`else
              {HI, LO} <= stage;
`endif
            end
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Move-from read port: current HI/LO, zero for every other op
  always_comb begin
    rd_data = 32'd0;
    if (mdu_op == MDU_mfhi)      rd_data = HI;
    else if (mdu_op == MDU_mflo) rd_data = LO;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_mdu_ctrl;

  localparam int unsigned MULT = 5;
  localparam int unsigned DIVC = 10;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;
  logic [63:0] exp_q[$];

  mdu_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIVC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO),
    .rd_data (rd_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                                input logic [31:0] b, input logic [31:0] hi,
                                                input logic [31:0] lo);
    longint p;
    longint q;
    longint r;
    logic [63:0] cur;
    cur = {hi, lo};
    case (op)
      OP_MULT, OP_MADD, OP_MSUB: p = longint'($signed(a)) * longint'($signed(b));
      default:                   p = longint'({32'd0, a}) * longint'({32'd0, b});
    endcase
    case (op)
      OP_MULT, OP_MULTU: return 64'(p);
      OP_MADD, OP_MADDU: return cur + 64'(p);
      OP_MSUB:           return cur - 64'(p);
      OP_DIV: begin
        if (b == 32'd0) return cur;
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
      default: return cur;
    endcase
  endfunction

  function automatic bit is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  // apply one clock edge to the model, using the inputs currently driven
  task automatic model_edge();
    if (!reset) begin
      m_hi = 32'd0;
      m_lo = 32'd0;
      m_left = 0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        if (exp_q.size() == 0) chk("model_queue_empty", 64'd1, 64'd0);
        else {m_hi, m_lo} = exp_q.pop_front();
      end
    end else if (start) begin
      if (is_mul_op(mdu_op)) begin
        exp_q.push_back(model_result(mdu_op, A, B, m_hi, m_lo));
        m_left = MULT;
      end else if (mdu_op == OP_DIV || mdu_op == OP_DIVU) begin
        exp_q.push_back(model_result(mdu_op, A, B, m_hi, m_lo));
        m_left = DIVC;
      end else if (mdu_op == OP_MTHI) begin
        m_hi = A;
      end else if (mdu_op == OP_MTLO) begin
        m_lo = A;
      end
    end
  endtask

  // ---------------- driver + compare ----------------
  task automatic step(input logic rst, input logic st, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_rd;
    reset = rst; start = st; mdu_op = op; A = a; B = b;
    #1;
    exp_rd = (op == OP_MFHI) ? m_hi : (op == OP_MFLO) ? m_lo : 32'd0;
    chk("rd_data", {32'd0, rd_data}, {32'd0, exp_rd});
    @(posedge clk);
    model_edge();
    #1;
    chk("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
    chk("HI", {32'd0, HI}, {32'd0, m_hi});
    chk("LO", {32'd0, LO}, {32'd0, m_lo});
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // issue an op, then idle until busy drops; cnt = cycles busy was high
  task automatic issue_wait(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cnt);
    int guard;
    step(1'b1, 1'b1, op, a, b);
    cnt = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      cnt++;
      idle();
      guard++;
    end
    if (guard >= 200) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    logic [3:0] rop;
    m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    reset = 1'b0; start = 1'b0; mdu_op = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_HI", {32'd0, HI}, 64'd0);
    chk("reset_LO", {32'd0, LO}, 64'd0);

    // reset mid-op: no late write
    step(1'b1, 1'b1, OP_MULT, 32'd7, 32'd6);
    idle();
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (10) idle();
    chk("midreset_HILO", {HI, LO}, 64'd0);

    // mult / multu
    issue_wait(OP_MULT, 32'hFFFF_FFFF, 32'd2, cnt);
    chk("mult_busy_cycles", 64'(cnt), 64'd5);
    chk("mult_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
    issue_wait(OP_MULTU, 32'hFFFF_FFFF, 32'd2, cnt);
    chk("multu_HILO", {HI, LO}, 64'h0000_0001_FFFF_FFFE);

    // div -7/2 and divu by zero
    issue_wait(OP_DIV, 32'hFFFF_FFF9, 32'd2, cnt);
    chk("div_busy_cycles", 64'(cnt), 64'd10);
    chk("div_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue_wait(OP_DIVU, 32'd7, 32'd0, cnt);
    chk("divz_busy_cycles", 64'(cnt), 64'd10);
    chk("divz_HILO", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    // mthi then mflo / mfhi in the same cycle as the request
    step(1'b1, 1'b1, OP_MTHI, 32'h0000_1234, 32'd0);
    mdu_op = OP_MFLO; start = 1'b1; #1;
    chk("mflo_lit", {32'd0, rd_data}, 64'hFFFF_FFFD);
    step(1'b1, 1'b1, OP_MFLO, 32'd0, 32'd0);
    mdu_op = OP_MFHI; #1;
    chk("mfhi_lit", {32'd0, rd_data}, 64'h1234);
    step(1'b1, 1'b1, OP_MFHI, 32'd0, 32'd0);
    mdu_op = OP_MULT; #1;
    chk("rd_nonmf_lit", {32'd0, rd_data}, 64'd0);

    // mult start during a div is ignored
    step(1'b1, 1'b1, OP_DIV, 32'd100, 32'd7);
    repeat (3) step(1'b1, 1'b1, OP_MULT, 32'd3, 32'd3);
    step(1'b1, 1'b1, OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    while (busy === 1'b1 && m_left > 0) idle();
    chk("div_ignore_HILO", {HI, LO}, {32'd2, 32'd14});

    // signed overflow case
    issue_wait(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cnt);
    chk("divovf_HILO", {HI, LO}, {32'd0, 32'h8000_0000});

    // back-to-back: new mult on the first cycle busy is low
    issue_wait(OP_MULT, 32'd3, 32'd4, cnt);
    step(1'b1, 1'b1, OP_MULT, 32'd5, 32'd5);
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    chk("b2b_prev_LO", {32'd0, LO}, 64'd12);
    while (busy === 1'b1 && m_left > 0) idle();
    chk("b2b_LO", {32'd0, LO}, 64'd25);

`ifdef MDU_MADD_EN
    step(1'b1, 1'b1, OP_MTHI, 32'd0, 32'd0);
    step(1'b1, 1'b1, OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue_wait(OP_MADD, 32'd1, 32'd1, cnt);
    chk("madd_busy_cycles", 64'(cnt), 64'd5);
    chk("madd_HILO", {HI, LO}, {32'd1, 32'd0});
`else
    step(1'b1, 1'b1, OP_MADD, 32'd3, 32'd4);
    chk("op9_busy", {63'd0, busy}, 64'd0);
    chk("op9_HILO", {HI, LO}, {32'd0, 32'd25});
`endif

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rop = ($urandom_range(0, 12) == 12) ? 4'd15 : 4'($urandom_range(0, 11));
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 4), rop, pick(), pick());
    end
    repeat (12) idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide unit with its sequencer. It sits beside the ALU in the EX stage of the pipelined core and owns the HI/LO registers. It accepts one mult/div/move operation per start pulse and holds busy for a fixed latency, so the hazard unit can stall HI/LO accesses.

Parameters:
MULT_CYCLES, 5, cycles busy is held for mult/multu (>=1)
DIV_CYCLES, 10, cycles busy is held for div/divu (>=1)

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-low (0 = reset), sampled on rising clk
start  input  1  EX-stage instruction is an MDU op; qualified by mdu_op
mdu_op  input  4  operation code (package constants)
A  input  32  rs operand
B  input  32  rt operand
busy  output  1  registered; high while a mult/div is in flight
HI  output  32  HI register
LO  output  32  LO register
rd_data  output  32  combinational: HI for MDU_mfhi, LO for MDU_mflo, else 0

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, busy=0, HI=0, LO=0, counter=0. Any in-flight op is aborted and its result is discarded. Reset has priority over start.
- States: IDLE, MUL, DIV.
- IDLE, start=1, op mult/multu: latch product of A,B (signed/unsigned, 64-bit) into a staging register. Go to MUL, counter<=MULT_CYCLES-1, busy<=1.
- IDLE, start=1, op div/divu: latch LO_stage=quotient and HI_stage=remainder. Go to DIV, counter<=DIV_CYCLES-1, busy<=1.
- MUL/DIV: counter decrements every edge. At the edge where counter==0: {HI,LO}<=staging, busy<=0, go to IDLE. busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles, and the result is visible in the first cycle busy is low.
- mthi/mtlo in IDLE with start=1: HI<=A or LO<=A at that edge. Single cycle, no busy.
- mfhi/mflo: no state change. rd_data reflects current HI/LO in the same cycle.
- start while busy=1: ignored, no state change. The hazard unit stalls on (busy | start&&mult/div) so this does not occur in a legal stream. The bench still checks that it is ignored.
- Unknown or none op with start=1: no effect.
- Arithmetic rules:
  - Signed ops use two's complement.
  - Signed div quotient truncates toward zero; remainder takes the sign of the dividend.
  - div/divu with B==0: the op still runs DIV_CYCLES with busy, but HI/LO are left unchanged at completion.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Outputs never go X. rd_data is 0 for all non-mf ops.

Optional Feature:
MDU_MADD_EN:
- Defined: adds MDU_madd, MDU_maddu, MDU_msub (codes 9..11). Each runs MULT_CYCLES like mult. At completion {HI,LO}<={HI,LO} ± product (64-bit wrap, signed or unsigned product per op). The accumulate uses {HI,LO} as it stands at completion.
- Not defined: codes 9..11 are treated as unknown (no effect), and no accumulate adder is synthesised.

Decomposition:
- Shared package/include (alongside the ALU op defines):
  - MDU op codes: none=0, mult=1, multu=2, div=3, divu=4, mthi=5, mtlo=6, mfhi=7, mflo=8, madd=9, maddu=10, msub=11.
  - State encodings IDLE/MUL/DIV.
  - Default latencies.
- One sub-module, mdu_arith: purely combinational signed/unsigned 64-bit product, quotient/remainder, div-by-zero flag and overflow case. mdu_ctrl holds the FSM, counter, staging and HI/LO.

Test Plan:
- Reset mid-op: mult 7*6 started, reset low 2 cycles later -> busy=0, HI=LO=0 next cycle; no late write.
- mult A=0xFFFFFFFF, B=2: busy high exactly 5 cycles -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
- mthi 0x1234 then mflo/mfhi -> rd_data=LO, then 0x1234 in the same cycle. A start of mult during busy (after div started) -> ignored; div result unaffected.
- Signed 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Back-to-back mult issued on the cycle busy falls -> accepted, busy re-asserts next cycle.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd 1*1 -> HI=1, LO=0. Without the macro, op 9 -> HI/LO unchanged and busy stays 0.
